// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: animation tick divider, stand/run/jump motion FSM with
// facing tracking, frame selector, and a one-cycle registered sprite ROM
// address path.
// Build option: define SPRITE_ANIM_MIRROR_EN to mirror ROM addresses
// horizontally when the character faces left. Without it, rom_addr passes
// pix_addr through (range-checked), and no divide/modulo logic exists.
//
// Pixel handshake: pix_valid qualifies pix_addr in the cycle it is high.
// rom_valid qualifies rom_addr exactly one clock later. There is no
// back-pressure (no ready), so every qualified pixel produces a result.
// A pixel that lies outside the sprite box returns rom_valid=0, rom_addr=0.

module sprite_anim_ctrl #(
  parameter int FRAME_DIV       = 6000000,
  parameter int TICKS_PER_FRAME = 4,
  parameter int SPR_W           = 47,
  parameter int SPR_H           = 87
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_l,
  input  logic        move_r,
  input  logic        jump_req,
  input  logic        on_ground,
  input  logic [11:0] pix_addr,
  input  logic        pix_valid,
  output logic [2:0]  anim_state,
  output logic [1:0]  frame_idx,
  output logic        frame_tick,
  output logic [11:0] rom_addr,
  output logic        rom_valid
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int SUB_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(TICKS_PER_FRAME - 1);
  localparam logic [12:0]      PIX_COUNT = 13'(SPR_W * SPR_H);

  // Motion encoding doubles as anim_state[2:1].
  typedef enum logic [1:0] {
    ST_STAND = 2'b00,
    ST_RUN   = 2'b01,
    ST_JUMP  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              airborne_q, airborne_d;
  logic              facing_q, facing_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [1:0]        frame_q, frame_d;
  logic [11:0]       rom_addr_q, rom_addr_d;
  logic              rom_valid_q, rom_valid_d;

  logic              tick_w;
  logic              only_l, only_r;
  state_e            walk_state;
  logic              in_range;
  logic [11:0]       mapped_addr;

  // Key decode shared by the FSM and the facing tracker.
  always_comb begin
    only_l     = move_l & ~move_r;
    only_r     = move_r & ~move_l;
    walk_state = (only_l | only_r) ? ST_RUN : ST_STAND;
  end

  // Tick divider: free-running 0..FRAME_DIV-1, pulse on the last count.
  always_comb begin
    tick_w = (div_q == DIV_LAST);
    div_d  = tick_w ? '0 : div_q + DIV_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  // FSM state register (motion state plus the airborne flag of a jump).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STAND;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      airborne_q <= airborne_d;
    end
  end

  // FSM next state: a grounded jump request wins from any state; a jump only
  // ends after the character has left the ground and landed again.
  always_comb begin
    state_d    = state_q;
    airborne_d = airborne_q;
    if (jump_req && on_ground) begin
      state_d    = ST_JUMP;
      airborne_d = 1'b0;
    end else begin
      case (state_q)
        ST_STAND, ST_RUN: begin
          state_d    = walk_state;
          airborne_d = 1'b0;
        end
        ST_JUMP: begin
          if (airborne_q && on_ground) begin
            state_d    = walk_state;
            airborne_d = 1'b0;
          end else if (!on_ground) begin
            airborne_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_STAND;
          airborne_d = 1'b0;
        end
      endcase
    end
  end

  // FSM outputs: motion and facing are exposed directly on anim_state.
  always_comb begin
    anim_state = {state_q, facing_q};
    frame_idx  = frame_q;
    frame_tick = tick_w;
  end

  // Facing follows a single held direction key, in every motion state.
  always_comb begin
    if (only_r)      facing_d = 1'b1;
    else if (only_l) facing_d = 1'b0;
    else             facing_d = facing_q;
  end

  // Facing register; reset faces right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) facing_q <= 1'b1;
    else     facing_q <= facing_d;
  end

  // Frame sequencing: a motion change restarts the sequence and swallows a
  // coincident tick; a jump pins the sequence at frame 0.
  always_comb begin
    sub_d   = sub_q;
    frame_d = frame_q;
    if ((state_d != state_q) || (state_q == ST_JUMP)) begin
      sub_d   = '0;
      frame_d = 2'd0;
    end else if (tick_w) begin
      if (sub_q == SUB_LAST) begin
        sub_d   = '0;
        frame_d = frame_q + 2'd1;
      end else begin
        sub_d   = sub_q + SUB_W'(1);
      end
    end
  end

  // Frame sequencing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q   <= '0;
      frame_q <= 2'd0;
    end else begin
      sub_q   <= sub_d;
      frame_q <= frame_d;
    end
  end

`ifdef SPRITE_ANIM_MIRROR_EN
  localparam logic [11:0] W12 = 12'(SPR_W);
  logic [11:0] row_w;
  logic [11:0] col_w;
  logic [11:0] mirror_w;

  // Horizontal mirror inside the sprite row: column c becomes SPR_W-1-c.
  always_comb begin
    row_w    = pix_addr / W12;
    col_w    = pix_addr % W12;
    mirror_w = (row_w * W12) + (W12 - 12'd1 - col_w);
    // The registered facing applies, so a mid-line turn affects the next pixel.
    mapped_addr = facing_q ? pix_addr : mirror_w;
  end
`else
  // No mirroring in this build: the ROM is addressed in raster order.
  always_comb begin
    mapped_addr = pix_addr;
  end
`endif

  // ROM request: only in-box qualified pixels produce a valid address.
  always_comb begin
    in_range    = pix_valid && ({1'b0, pix_addr} < PIX_COUNT);
    rom_valid_d = in_range;
    rom_addr_d  = in_range ? mapped_addr : 12'd0;
  end

  // ROM request register (one clock of latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q  <= 12'd0;
      rom_valid_q <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      rom_valid_q <= rom_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_valid = rom_valid_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl with FRAME_DIV=4, TICKS_PER_FRAME=4, 47x87 sprite.
// Mirrored addresses are expected only when SPRITE_ANIM_MIRROR_EN is defined.

module tb_sprite_anim_ctrl;

  localparam int FRAME_DIV = 4;
  localparam int TPF       = 4;
  localparam int SPR_W     = 47;
  localparam int SPR_H     = 87;

`ifdef SPRITE_ANIM_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        move_l, move_r, jump_req, on_ground;
  logic [11:0] pix_addr;
  logic        pix_valid;
  logic [2:0]  anim_state;
  logic [1:0]  frame_idx;
  logic        frame_tick;
  logic [11:0] rom_addr;
  logic        rom_valid;

  // Clock / reset block.
  always #5 clk = ~clk;

  sprite_anim_ctrl #(
    .FRAME_DIV      (FRAME_DIV),
    .TICKS_PER_FRAME(TPF),
    .SPR_W          (SPR_W),
    .SPR_H          (SPR_H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .move_l    (move_l),
    .move_r    (move_r),
    .jump_req  (jump_req),
    .on_ground (on_ground),
    .pix_addr  (pix_addr),
    .pix_valid (pix_valid),
    .anim_state(anim_state),
    .frame_idx (frame_idx),
    .frame_tick(frame_tick),
    .rom_addr  (rom_addr),
    .rom_valid (rom_valid)
  );

  // Scoreboard queues: state record {anim_state, frame_idx, frame_tick},
  // pixel record {rom_valid, rom_addr}.
  logic [5:0]  st_q[$];
  logic [12:0] pix_q[$];
  logic        st_req  = 1'b0;
  logic        pix_req = 1'b0;
  int          checks  = 0;
  int          passed  = 0;
  int          n       = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, n);
  endtask

  function automatic logic [5:0] st(input logic [2:0] a, input logic [1:0] f, input logic t);
    return {a, f, t};
  endfunction

  function automatic logic [11:0] mx(input int mirrored, input int plain);
    return MIR ? 12'(mirrored) : 12'(plain);
  endfunction

  // Driver tasks: expectations apply to the outputs right after the next edge.
  task automatic exp_st(input logic [5:0] e);
    st_q.push_back(e);
    st_req = 1'b1;
  endtask

  task automatic drive_pix(input logic v, input logic [11:0] a, input logic [12:0] e);
    pix_valid = v;
    pix_addr  = a;
    pix_q.push_back(e);
    pix_req   = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    st_req    = 1'b0;
    pix_req   = 1'b0;
    pix_valid = 1'b0;
    pix_addr  = 12'd0;
  endtask

  task automatic check_reset(input string name);
    check({name, "_anim"},  {13'd0, anim_state}, 16'd1);
    check({name, "_frame"}, {14'd0, frame_idx},  16'd0);
    check({name, "_tick"},  {15'd0, frame_tick}, 16'd0);
    check({name, "_rvld"},  {15'd0, rom_valid},  16'd0);
    check({name, "_raddr"}, {4'd0, rom_addr},    16'd0);
  endtask

  // Monitor: pops and compares whenever an expectation was armed for an edge.
  initial begin
    logic        ps, ss;
    logic [5:0]  es;
    logic [12:0] ep;
    forever begin
      @(posedge clk);
      ps = pix_req;
      ss = st_req;
      #1;
      if (ps) begin
        if (pix_q.size() == 0) begin
          checks++;
          $display("FAIL pix_q_underflow at edge %0d", n + 1);
        end else begin
          ep = pix_q.pop_front();
          check("rom_out", {3'd0, rom_valid, rom_addr}, {3'd0, ep});
        end
      end
      if (ss) begin
        if (st_q.size() == 0) begin
          checks++;
          $display("FAIL st_q_underflow at edge %0d", n + 1);
        end else begin
          es = st_q.pop_front();
          check("anim_frame_tick", {10'd0, anim_state, frame_idx, frame_tick}, {10'd0, es});
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1; move_l = 1'b0; move_r = 1'b0; jump_req = 1'b0; on_ground = 1'b1;
    pix_addr = 12'd0; pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    n   = 0;

    // Idle: standing, facing right, frames advance every 16 edges.
    for (int e = 1; e <= 66; e++) begin
      exp_st(st(3'b001, 2'((e / 16) % 4), (e % 4) == 3));
      step();
    end

    // Run left; mirrored pixel fetches and range boundaries.
    move_l = 1'b1;
    for (int e = 67; e <= 100; e++) begin
      exp_st(st(3'b010, 2'(((e - 64) / 16) % 4), (e % 4) == 3));
      case (e)
        68: drive_pix(1'b1, 12'd0,    {1'b1, mx(46, 0)});
        69: drive_pix(1'b1, 12'd47,   {1'b1, mx(93, 47)});
        70: drive_pix(1'b1, 12'd4088, {1'b1, mx(4042, 4088)});
        71: drive_pix(1'b1, 12'd4089, 13'd0);
        72: drive_pix(1'b0, 12'd5,    13'd0);
        73: drive_pix(1'b1, 12'd100,  {1'b1, mx(134, 100)});
        default: ;
      endcase
      step();
    end

    // Jump from RUN at frame 2: frame drops to 0.
    jump_req = 1'b1;
    exp_st(st(3'b100, 2'd0, 1'b0));
    step();
    jump_req = 1'b0;
    for (int e = 102; e <= 103; e++) begin
      exp_st(st(3'b100, 2'd0, (e % 4) == 3));
      step();
    end

    // Leave the ground and turn right mid-line while airborne.
    on_ground = 1'b0; move_l = 1'b0; move_r = 1'b1;
    exp_st(st(3'b101, 2'd0, 1'b0));
    drive_pix(1'b1, 12'd0, {1'b1, mx(46, 0)});
    step();
    exp_st(st(3'b101, 2'd0, 1'b0));
    drive_pix(1'b1, 12'd1, {1'b1, 12'd1});
    step();
    for (int e = 106; e <= 107; e++) begin
      exp_st(st(3'b101, 2'd0, (e % 4) == 3));
      step();
    end

    // Land with move_r held on an edge that also carries a tick (discarded).
    on_ground = 1'b1;
    for (int e = 108; e <= 126; e++) begin
      exp_st(st(3'b011, (e >= 124) ? 2'd1 : 2'd0, (e % 4) == 3));
      step();
    end

    // Both keys: stand, facing held right.
    move_l = 1'b1;
    exp_st(st(3'b001, 2'd0, 1'b1));
    step();

    // Jump facing left, go airborne, then reset mid-jump.
    move_r = 1'b0; jump_req = 1'b1;
    exp_st(st(3'b100, 2'd0, 1'b0));
    step();
    jump_req = 1'b0; on_ground = 1'b0;
    for (int e = 129; e <= 131; e++) begin
      exp_st(st(3'b100, 2'd0, (e % 4) == 3));
      if (e == 131) drive_pix(1'b1, 12'd5, {1'b1, mx(41, 5)});
      step();
    end
    #2 rst = 1'b1;
    #1 check_reset("async_reset");

    @(negedge clk);
    move_l = 1'b1; move_r = 1'b1; on_ground = 1'b1; jump_req = 1'b0;
    rst = 1'b0;
    n   = 0;
    for (int e = 1; e <= 4; e++) begin
      exp_st(st(3'b001, 2'd0, (e % 4) == 3));
      step();
    end

    repeat (2) @(negedge clk);
    check("queues_drained", 16'(st_q.size() + pix_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
